// File: rtl/ex_div.sv
// Multi-cycle RV32M divider for the EX stage: restoring division, one quotient bit per cycle.
// Divide-by-zero and signed overflow finish early without entering the iterative loop.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o
);

  typedef enum logic [1:0] {IDLE, START, CALC, END} state_t;

  state_t      state_reg, state_next;
  // op_reg[1]: remainder requested, op_reg[0]: unsigned operation
  logic [1:0]  op_reg, op_next;
  logic [31:0] dividend_reg, dividend_next;
  logic [31:0] divisor_reg, divisor_next;
  logic [4:0]  waddr_reg, waddr_next;
  logic [31:0] dvd_reg, dvd_next;
  logic [31:0] dvs_reg, dvs_next;
  logic [31:0] quo_reg, quo_next;
  logic [31:0] rem_reg, rem_next;
  logic [4:0]  cnt_reg, cnt_next;

  logic        accept;
  logic        a_neg, b_neg;
  logic [32:0] rem_shift, diff;
  logic        step_ge;
  logic [31:0] rem_step, quo_step;

  assign accept = start_i & op_i[2] & ~flush_i;
  assign a_neg  = ~op_reg[0] & dividend_reg[31];
  assign b_neg  = ~op_reg[0] & divisor_reg[31];

  // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
  assign rem_shift = {rem_reg, dvd_reg[31]};
  assign diff      = rem_shift - {1'b0, dvs_reg};
  assign step_ge   = ~diff[32];
  assign rem_step  = step_ge ? diff[31:0] : rem_shift[31:0];
  assign quo_step  = {quo_reg[30:0], step_ge};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      waddr_reg    <= '0;
      dvd_reg      <= '0;
      dvs_reg      <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      waddr_reg    <= waddr_next;
      dvd_reg      <= dvd_next;
      dvs_reg      <= dvs_next;
      quo_reg      <= quo_next;
      rem_reg      <= rem_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    waddr_next    = waddr_reg;
    dvd_next      = dvd_reg;
    dvs_next      = dvs_reg;
    quo_next      = quo_reg;
    rem_next      = rem_reg;
    cnt_next      = cnt_reg;
    busy_o        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          busy_o        = rst;
          op_next       = op_i[1:0];
          dividend_next = dividend_i;
          divisor_next  = divisor_i;
          waddr_next    = reg_waddr_i;
          state_next    = START;
        end
      end
      START: begin
        busy_o = 1'b1;
        if (flush_i) begin
          state_next = IDLE;
        end else if (divisor_reg == 32'd0) begin
          quo_next   = 32'hFFFF_FFFF;
          rem_next   = dividend_reg;
          state_next = END;
        end else if (!op_reg[0] && dividend_reg == 32'h8000_0000 &&
                     divisor_reg == 32'hFFFF_FFFF) begin
          quo_next   = 32'h8000_0000;
          rem_next   = 32'd0;
          state_next = END;
        end else begin
          dvd_next   = a_neg ? (32'd0 - dividend_reg) : dividend_reg;
          dvs_next   = b_neg ? (32'd0 - divisor_reg) : divisor_reg;
          quo_next   = 32'd0;
          rem_next   = 32'd0;
          cnt_next   = 5'd31;
          state_next = CALC;
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (flush_i) begin
          state_next = IDLE;
        end else begin
          dvd_next = {dvd_reg[30:0], 1'b0};
          cnt_next = cnt_reg - 5'd1;
          quo_next = quo_step;
          rem_next = rem_step;
          // Last step: fold the sign correction into the final write.
          if (cnt_reg == 5'd0) begin
            quo_next   = (a_neg ^ b_neg) ? (32'd0 - quo_step) : quo_step;
            rem_next   = a_neg ? (32'd0 - rem_step) : rem_step;
            state_next = END;
          end
        end
      end
      END: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready_o     = (state_reg == END) & ~flush_i;
  assign reg_we_o    = ready_o;
  assign result_o    = ready_o ? (op_reg[1] ? rem_reg : quo_reg) : 32'd0;
  assign reg_waddr_o = ready_o ? waddr_reg : 5'd0;

endmodule

// File: tb/tb_ex_div.sv
// Bench for ex_div: vector table through a result scoreboard, plus flush and reset sequences.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] dividend_i = 32'd0;
  logic [31:0] divisor_i = 32'd0;
  logic [4:0]  reg_waddr_i = 5'd0;
  logic        flush_i = 1'b0;
  logic        busy_o, ready_o, reg_we_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  int total = 0;
  int bad = 0;

  ex_div dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i),
    .flush_i(flush_i), .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  vec_t vecs[18];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({name, "_ready"}, {31'd0, ready_o}, 32'd0);
    check({name, "_we"}, {31'd0, reg_we_o}, 32'd0);
    check({name, "_result"}, result_o, 32'd0);
    check({name, "_waddr"}, {27'd0, reg_waddr_o}, 32'd0);
  endtask

  task automatic run_op(input vec_t v);
    int   cyc;
    int   busy_cnt;
    int   nz;
    bit   got;
    exp_t e;
    @(negedge clk);
    op_i = v.op; dividend_i = v.a; divisor_i = v.b; reg_waddr_i = v.rd; start_i = 1'b1;
    #1;
    check("busy_cycle0", {31'd0, busy_o}, 32'd1);
    sb.push_back('{v.exp, v.rd, v.lat});
    cyc = 0; busy_cnt = 1; nz = 0; got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (ready_o) got = 1'b1;
      else begin
        if (busy_o) busy_cnt++;
        if (result_o != 32'd0 || reg_waddr_o != 5'd0 || reg_we_o) nz++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      check("ready_seen", {31'd0, ready_o}, 32'd1);
    end else begin
      check("latency", cyc, e.lat);
      check("result", result_o, e.res);
      check("waddr", {27'd0, reg_waddr_o}, {27'd0, e.rd});
      check("reg_we", {31'd0, reg_we_o}, 32'd1);
      check("busy_at_end", {31'd0, busy_o}, 32'd0);
      check("busy_cycles", busy_cnt, e.lat);
      check("idle_outputs_zero", nz, 0);
    end
    $display("op=%b a=%h b=%h rd=%0d -> result=%h waddr=%0d latency=%0d", v.op, v.a, v.b,
             v.rd, result_o, reg_waddr_o, cyc);
    start_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy;
    vecs[0]  = '{DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34};
    vecs[1]  = '{REMU, 32'd100, 32'd7, 5'd5, 32'd2, 34};
    vecs[2]  = '{DIV,  32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 34};
    vecs[3]  = '{REM,  32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{DIVU, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF, 2};
    vecs[5]  = '{REM,  32'd5, 32'd0, 5'd4, 32'd5, 2};
    vecs[6]  = '{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 2};
    vecs[7]  = '{REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0, 2};
    vecs[8]  = '{DIVU, 32'd9, 32'd3, 5'd8, 32'd3, 34};
    vecs[9]  = '{DIV,  32'hFFFF_FF9C, 32'd7, 5'd9, 32'hFFFF_FFF2, 34};
    vecs[10] = '{REM,  32'hFFFF_FF9C, 32'd7, 5'd10, 32'hFFFF_FFFE, 34};
    vecs[11] = '{DIV,  32'd100, 32'hFFFF_FFF9, 5'd11, 32'hFFFF_FFF2, 34};
    vecs[12] = '{REM,  32'd100, 32'hFFFF_FFF9, 5'd12, 32'd2, 34};
    vecs[13] = '{DIVU, 32'hFFFF_FFFF, 32'd1, 5'd13, 32'hFFFF_FFFF, 34};
    vecs[14] = '{REMU, 32'hFFFF_FFFF, 32'd10, 5'd14, 32'd5, 34};
    vecs[15] = '{DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 34};
    vecs[16] = '{REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 34};
    vecs[17] = '{DIV,  32'hFFFF_FFFA, 32'hFFFF_FFFD, 5'd17, 32'd2, 34};

    // Reset state, with a valid request already presented.
    start_i = 1'b1; op_i = DIVU; dividend_i = 32'd1; divisor_i = 32'd1; reg_waddr_i = 5'd9;
    #12;
    check_outputs_zero("reset");
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Non-divide funct3 must not be accepted.
    @(negedge clk);
    op_i = 3'b011; dividend_i = 32'd8; divisor_i = 32'd2; reg_waddr_i = 5'd4; start_i = 1'b1;
    #1;
    check("nondiv_busy", {31'd0, busy_o}, 32'd0);
    rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o || busy_o) rdy++;
    end
    check("nondiv_no_activity", rdy, 0);
    start_i = 1'b0;

    // Flush in CALC at cycle 10, then a new divide accepted at cycle 12.
    @(negedge clk);
    op_i = DIVU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd5; start_i = 1'b1;
    rdy = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o) rdy++;
    end
    flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("flush_idle_busy", {31'd0, busy_o}, 32'd0);
    check("flush_no_ready", rdy + int'(ready_o), 0);
    flush_i = 1'b0; start_i = 1'b0;
    run_op('{DIVU, 32'd9, 32'd3, 5'd5, 32'd3, 34});

    // Flush during END suppresses the write-back strobe.
    @(negedge clk);
    op_i = REMU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd21; start_i = 1'b1;
    repeat (34) @(posedge clk);
    @(negedge clk);
    check("end_ready_before_flush", {31'd0, ready_o}, 32'd1);
    flush_i = 1'b1;
    #1;
    check_outputs_zero("end_flush");
    @(posedge clk);
    @(negedge clk);
    check("end_flush_idle", {31'd0, busy_o | ready_o}, 32'd0);
    flush_i = 1'b0; start_i = 1'b0;
    $display("flush in END: result=%h ready=%0d", result_o, ready_o);

    // Asynchronous reset mid-CALC abandons the operation.
    @(negedge clk);
    op_i = DIVU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd5; start_i = 1'b1;
    repeat (21) @(posedge clk);
    #2;
    check("calc_busy_before_reset", {31'd0, busy_o}, 32'd1);
    rst = 1'b0;
    #1;
    check_outputs_zero("midcalc_reset");
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) rdy++;
    end
    check("post_reset_no_ready", rdy, 0);
    $display("reset mid-CALC: ready pulses after release=%0d", rdy);

    run_op('{DIV, 32'hFFFF_FFF9, 32'd0, 5'd30, 32'hFFFF_FFFF, 2});
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits and the register address width at 5 bits.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; assertion clears all state immediately, independent of clk.
REQ-004 start_i  input  1  divide request from the EX stage, level, held by EX for the life of the instruction.
REQ-005 op_i  input  3  RV32M funct3: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU.
REQ-006 dividend_i  input  32  rs1 operand (EX op1).
REQ-007 divisor_i  input  32  rs2 operand (EX op2).
REQ-008 reg_waddr_i  input  5  destination register of the divide instruction.
REQ-009 flush_i  input  1  synchronous abort of any operation in flight.
REQ-010 busy_o  output  1  pipeline hold request to the control unit.
REQ-011 ready_o  output  1  one-cycle result-valid strobe.
REQ-012 result_o  output  32  quotient or remainder; zero whenever ready_o=0.
REQ-013 reg_we_o  output  1  register write enable; equal to ready_o.
REQ-014 reg_waddr_o  output  5  latched destination; zero whenever ready_o=0.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, START, CALC, END.
REQ-016 In IDLE, if start_i=1, op_i[2]=1 and flush_i=0 at a rising edge, the block SHALL latch op_i, dividend_i, divisor_i and reg_waddr_i, then enter START; otherwise it SHALL remain in IDLE.
REQ-017 busy_o SHALL be 1 combinationally in IDLE when the accept condition of REQ-016 holds, SHALL be 1 in START and CALC, and SHALL be 0 in END and otherwise.
REQ-018 In START, if the latched divisor is 0, the block SHALL set the quotient to 0xFFFFFFFF and the remainder to the latched dividend, then enter END.
REQ-019 In START, for signed DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF, the block SHALL set the quotient to 0x80000000 and the remainder to 0, then enter END.
REQ-020 In START, in all other cases, the block SHALL load the magnitudes of the operands (two's-complement absolute value for DIV/REM, raw values for DIVU/REMU), clear the partial remainder, load a 5-bit counter with 31, and enter CALC.
REQ-021 In each CALC cycle, the block SHALL perform one restoring-division step: shift the remainder left 1 while bringing in the next dividend MSB, trial-subtract the divisor, keep the difference and set the quotient bit if it is non-negative, and decrement the counter.
REQ-022 CALC SHALL last exactly 32 cycles; when the counter equals 0 the block SHALL apply sign correction and enter END.
REQ-023 Sign correction for DIV SHALL negate the quotient when the operand signs differ; for REM it SHALL give the remainder the sign of the dividend.
REQ-024 In END, ready_o and reg_we_o SHALL be 1 for exactly one cycle, with result_o equal to the quotient (DIV/DIVU) or the remainder (REM/REMU); the next state SHALL be IDLE.
REQ-025 start_i SHALL be ignored in START, CALC and END, so the same held instruction is never re-accepted.
REQ-026 Normal latency SHALL be 34 cycles from the accepting edge (cycle 0) to the ready_o cycle (cycle 34); the divide-by-zero and overflow paths SHALL take 2 cycles.
REQ-027 A start with op_i[2]=0 SHALL be ignored (busy_o=0, no state change).
REQ-028 flush_i=1 in START or CALC SHALL force IDLE at the next edge with no ready_o.
REQ-029 flush_i=1 in END SHALL suppress ready_o, reg_we_o, result_o and reg_waddr_o combinationally; the next state SHALL still be IDLE.
REQ-030 A new start SHALL be accepted in the first IDLE cycle after END or after a flush.

Reset
REQ-031 When rst=0, the state SHALL be IDLE, the counter and all operand, quotient and remainder registers SHALL be 0, and busy_o, ready_o, reg_we_o, result_o and reg_waddr_o SHALL be 0.
REQ-032 Reset asserted mid-CALC SHALL abandon the operation; after release, no ready_o SHALL occur until a new start is accepted.

Verification
REQ-033 DIVU 100/7, rd=5 -> busy_o=1 in cycles 0-33; ready_o=1 at cycle 34 with result_o=14, reg_waddr_o=5; REMU with the same operands -> result_o=2.
REQ-034 DIV 0xFFFFFFF9/2 -> result_o=0xFFFFFFFD; REM with the same operands -> result_o=0xFFFFFFFF.
REQ-035 DIVU 5/0 -> ready_o at cycle 2 with result_o=0xFFFFFFFF; REM 5/0 -> result_o=5.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> ready_o at cycle 2 with result_o=0x80000000; REM with the same operands -> result_o=0.
REQ-037 flush_i pulsed at cycle 10 -> IDLE at cycle 11, no ready_o; DIVU 9/3 accepted at cycle 12 -> ready_o at cycle 46 with result_o=3.
REQ-038 rst driven low at cycle 20 of CALC, between clock edges -> all outputs 0 immediately; after release with start_i=0 -> ready_o stays 0.
